// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial bit transmitter.
// Holds the FSM state encoding and the bit-order selector values.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam bit DIR_MSB = 1'b1;
    localparam bit DIR_LSB = 1'b0;

    localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter feeding the pattern-detector FSMs.
// Ports: clk, reset (sync, active-high); data_in/data_valid/data_ready
// word handshake; bit_en slot tick; out serial stream (registered);
// busy, frame_done pulse, det_expect golden "11" detect flag.
module serial_bit_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = DIR_MSB,
    parameter int GAP_BITS  = 0,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             bit_en,
    output logic             out,
    output logic             busy,
    output logic             frame_done,
    output logic             det_expect
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        (GAP_BITS > 0) ? GAP_CNT_W'(GAP_BITS - 1) : '0;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       shreg;
    logic [CW-1:0]          bit_cnt;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic                   prev_bit;

    logic                   accept;
    logic                   last_tick;
    logic                   gap_end;
    logic                   load_bit;
    logic [WIDTH-1:0]       load_rest;
    logic                   next_bit;
    logic [WIDTH-1:0]       next_rest;

    assign data_ready = (state == ST_IDLE) && !reset;
    assign accept     = data_valid && data_ready;
    assign busy       = (state != ST_IDLE);

    assign last_tick = (state == ST_SHIFT) && bit_en
                    && (bit_cnt == BIT_LAST);
    assign gap_end   = (state == ST_GAP) && bit_en
                    && (gap_cnt == GAP_LAST);

    // Pulses in the cycle whose bit_en retires the last bit, so the
    // IDLE cycle that follows is the earliest next accept.
    assign frame_done = last_tick && !reset;
    assign det_expect = prev_bit & out;

    // shreg holds the bits not yet on out, aligned so the next one
    // always sits at the end selected by the bit order.
    always_comb begin
        load_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
        load_rest = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
        next_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        next_rest = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_tick) begin
                    state_nxt = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= IDLE_BIT;
            prev_bit <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        prev_bit <= out;
                        out      <= load_bit;
                        shreg    <= load_rest;
                        bit_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_en) begin
                        prev_bit <= out;
                        if (bit_cnt == BIT_LAST) begin
                            out     <= IDLE_BIT;
                            gap_cnt <= '0;
                        end else begin
                            out     <= next_bit;
                            shreg   <= next_rest;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (bit_en) begin
                        prev_bit <= out;
                        out      <= IDLE_BIT;
                        if (gap_cnt != GAP_LAST) begin
                            gap_cnt <= gap_cnt + GAP_CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Self-checking bench for serial_bit_tx: an MSB-first no-gap instance
// and an LSB-first 3-slot-gap instance against a frame-level model.
module tb_serial_bit_tx;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0][7:0] din;
    logic [1:0]      valid;
    logic [1:0]      ready;
    logic [1:0]      ben;
    logic [1:0]      out;
    logic [1:0]      busy;
    logic [1:0]      fd;
    logic [1:0]      det;

    int ntests = 0;
    int nfail  = 0;

    logic r_bits [8];
    logic r_dets [8];
    int   r_fd, r_fd_at, r_viol, r_gviol;
    bit   r_acc_to;
    logic r_post_out, r_post_busy, r_post_ready;

    always #5 clk = ~clk;

    serial_bit_tx #(
        .WIDTH(8), .MSB_FIRST(1'b1), .GAP_BITS(0), .IDLE_BIT(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .data_in(din[0]),
        .data_valid(valid[0]), .data_ready(ready[0]),
        .bit_en(ben[0]), .out(out[0]), .busy(busy[0]),
        .frame_done(fd[0]), .det_expect(det[0])
    );

    serial_bit_tx #(
        .WIDTH(8), .MSB_FIRST(1'b0), .GAP_BITS(3), .IDLE_BIT(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .data_in(din[1]),
        .data_valid(valid[1]), .data_ready(ready[1]),
        .bit_en(ben[1]), .out(out[1]), .busy(busy[1]),
        .frame_done(fd[1]), .det_expect(det[1])
    );

    // Frame-level model: bit i of a word in transmission order.
    function automatic logic exp_bit(input int sel, input logic [7:0] w,
                                     input int i);
        return (sel == 0) ? w[7-i] : w[i];
    endfunction

    // Expected "11" flag for bit i; the slot before bit 0 is idle (0).
    function automatic logic exp_det(input int sel, input logic [7:0] w,
                                     input int i);
        if (i == 0) return 1'b0;
        return exp_bit(sel, w, i-1) & exp_bit(sel, w, i);
    endfunction

    // Sends one word and records what the DUT showed; tests judge it.
    // period < 0 gives random slot lengths.
    task automatic run_frame(input int sel, input logic [7:0] w,
                             input int nbits, input int period,
                             input int stall_at, input int stall_len);
        bit ok = 0;
        int gap = (sel == 1) ? 3 : 0;
        r_fd = 0; r_fd_at = -1; r_viol = 0; r_gviol = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            valid[sel] = 1'b1;
            din[sel]   = w;
            ben[sel]   = 1'($urandom_range(0, 1));
            #1;
            if (ready[sel]) ok = 1;
        end
        r_acc_to = !ok;
        for (int i = 0; i < nbits; i++) begin
            int idle;
            if (i == stall_at) idle = stall_len;
            else if (period < 0) idle = $urandom_range(0, 3);
            else idle = period - 1;
            for (int k = 0; k <= idle; k++) begin
                @(negedge clk);
                valid[sel] = 1'b0;
                din[sel]   = 8'($urandom);
                ben[sel]   = (k == idle);
                #1;
                if (k == 0) r_bits[i] = out[sel];
                if (out[sel] !== r_bits[i] || ready[sel] !== 1'b0
                    || busy[sel] !== 1'b1) r_viol++;
                if (fd[sel] === 1'b1) begin
                    r_fd++;
                    r_fd_at = i;
                end
            end
            r_dets[i] = det[sel];
        end
        if (nbits == 8) begin
            for (int g = 0; g < gap; g++) begin
                int idle = $urandom_range(0, 2);
                for (int k = 0; k <= idle; k++) begin
                    @(negedge clk);
                    ben[sel] = (k == idle);
                    #1;
                    if (out[sel] !== 1'b0 || ready[sel] !== 1'b0
                        || busy[sel] !== 1'b1) r_gviol++;
                    if (fd[sel] === 1'b1) r_fd++;
                end
            end
            @(negedge clk);
            ben[sel] = 1'b0;
            #1;
            r_post_out   = out[sel];
            r_post_busy  = busy[sel];
            r_post_ready = ready[sel];
        end
        ben[sel] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 2'b11; ben = 2'b00;
        din[0] = 8'hC3; din[1] = 8'h3C;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            ntests++;
            if (out !== 2'b00) begin
                nfail++;
                $display("FAIL reset_out cyc%0d got %b exp 00", c, out);
            end
            ntests++;
            if (ready !== 2'b00) begin
                nfail++;
                $display("FAIL reset_ready cyc%0d got %b exp 00", c, ready);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        ntests++;
        if (ready !== 2'b11) begin
            nfail++;
            $display("FAIL reset_ready_after got %b exp 11", ready);
        end
        ntests++;
        if (busy !== 2'b00 || fd !== 2'b00 || det !== 2'b00) begin
            nfail++;
            $display("FAIL reset_flags got busy=%b fd=%b det=%b exp 0",
                     busy, fd, det);
        end
        valid = 2'b00;
    endtask

    task automatic check_frame(input string tag, input int sel,
                               input logic [7:0] w);
        ntests++;
        if (r_acc_to !== 1'b0) begin
            nfail++;
            $display("FAIL %s accept_timeout got 1 exp 0", tag);
        end
        for (int i = 0; i < 8; i++) begin
            ntests++;
            if (r_bits[i] !== exp_bit(sel, w, i)) begin
                nfail++;
                $display("FAIL %s bit%0d got %b exp %b", tag, i,
                         r_bits[i], exp_bit(sel, w, i));
            end
            ntests++;
            if (r_dets[i] !== exp_det(sel, w, i)) begin
                nfail++;
                $display("FAIL %s det%0d got %b exp %b", tag, i,
                         r_dets[i], exp_det(sel, w, i));
            end
        end
        ntests++;
        if (r_fd !== 1 || r_fd_at !== 7) begin
            nfail++;
            $display("FAIL %s frame_done got n=%0d at=%0d exp n=1 at=7",
                     tag, r_fd, r_fd_at);
        end
        ntests++;
        if (r_viol !== 0 || r_gviol !== 0) begin
            nfail++;
            $display("FAIL %s slot_hold got %0d/%0d exp 0/0", tag,
                     r_viol, r_gviol);
        end
        ntests++;
        if (r_post_out !== 1'b0 || r_post_busy !== 1'b0
            || r_post_ready !== 1'b1) begin
            nfail++;
            $display("FAIL %s post got out=%b busy=%b rdy=%b exp 0 0 1",
                     tag, r_post_out, r_post_busy, r_post_ready);
        end
    endtask

    task automatic test_single();
        run_frame(0, 8'hB6, 8, 4, -1, 0);
        check_frame("single_B6", 0, 8'hB6);
    endtask

    task automatic test_lsb_gap();
        run_frame(1, 8'h03, 8, -1, -1, 0);
        check_frame("lsb_gap_03", 1, 8'h03);
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [2];
        logic       b [16];
        logic       d [16];
        int nb = 0, nfd = 0, nacc = 0, fd_cyc = -1, acc2 = -1;
        logic idle_out = 1'bx;
        w[0] = 8'hFF; w[1] = 8'h81;
        for (int cyc = 0; cyc < 600 && nfd < 2; cyc++) begin
            @(negedge clk);
            valid[0] = (nacc < 2);
            din[0]   = w[(nacc < 2) ? nacc : 1];
            ben[0]   = 1'($urandom_range(0, 1));
            #1;
            if (busy[0] && ben[0]) begin
                if (nb < 16) begin
                    b[nb] = out[0];
                    d[nb] = det[0];
                end
                nb++;
            end
            if (fd[0]) begin
                nfd++;
                if (nfd == 1) fd_cyc = cyc;
            end
            if (valid[0] && ready[0]) begin
                nacc++;
                if (nacc == 2) begin
                    acc2 = cyc;
                    idle_out = out[0];
                end
            end
        end
        valid[0] = 1'b0; ben[0] = 1'b0;
        ntests++;
        if (nfd !== 2 || nb !== 16) begin
            nfail++;
            $display("FAIL b2b_counts got fd=%0d bits=%0d exp 2 16",
                     nfd, nb);
        end
        ntests++;
        if (acc2 !== fd_cyc + 1) begin
            nfail++;
            $display("FAIL b2b_accept_cycle got %0d exp %0d",
                     acc2, fd_cyc + 1);
        end
        ntests++;
        if (idle_out !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_idle_slot got %b exp 0", idle_out);
        end
        for (int j = 0; j < 16 && j < nb; j++) begin
            ntests++;
            if (b[j] !== exp_bit(0, w[j/8], j%8)
                || d[j] !== exp_det(0, w[j/8], j%8)) begin
                nfail++;
                $display("FAIL b2b_bit%0d got out=%b det=%b exp %b %b", j,
                         b[j], d[j], exp_bit(0, w[j/8], j%8),
                         exp_det(0, w[j/8], j%8));
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] w2 = 8'($urandom);
        run_frame(0, 8'hAA, 3, -1, -1, 0);
        @(negedge clk);
        reset = 1'b1; ben[0] = 1'b0;
        #1;
        ntests++;
        if (fd[0] !== 1'b0 || r_fd !== 0) begin
            nfail++;
            $display("FAIL abort_no_done got %b/%0d exp 0/0", fd[0], r_fd);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        ntests++;
        if (out[0] !== 1'b0 || busy[0] !== 1'b0 || fd[0] !== 1'b0) begin
            nfail++;
            $display("FAIL abort_state got out=%b busy=%b fd=%b exp 000",
                     out[0], busy[0], fd[0]);
        end
        run_frame(0, w2, 8, -1, -1, 0);
        check_frame("abort_next", 0, w2);
    endtask

    task automatic test_stall();
        logic [7:0] w = 8'($urandom);
        run_frame(0, w, 8, 2, 4, 50);
        check_frame("stall", 0, w);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int sel = n % 2;
            logic [7:0] w = 8'($urandom);
            run_frame(sel, w, 8, -1, -1, 0);
            check_frame($sformatf("rand%0d", n), sel, w);
        end
    endtask

    initial begin
        reset = 1'b1;
        valid = 2'b00;
        ben   = 2'b00;
        din   = '0;
        test_reset();
        test_single();
        test_lsb_gap();
        test_back_to_back();
        test_abort();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
